glyph_renderer: RTL and testbench

- Text-mode pixel pipeline directly downstream of the VGA sync generator (800x600@60, 40 MHz).
- Consumes hpos/vpos/display_on/hsync/vsync and produces RRGGBB pixels with syncs re-aligned to the pixel latency.
- Fetches character codes from an external character buffer and glyph rows from an external font ROM. Both are synchronous memories with a 1-cycle read latency.

---
 rtl/glyph_renderer_if.sv | 10 +
 rtl/glyph_renderer.sv | 137 +++++++++++++
 tb/tb_glyph_renderer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/glyph_renderer_if.sv
// rtl/glyph_renderer_if.sv - character buffer and font ROM read bus for glyph_renderer
interface glyph_renderer_if;
    logic [8:0] char_addr;
    logic [7:0] char_code;
    logic [9:0] font_addr;
    logic [7:0] font_bits;

    modport master (output char_addr, output font_addr, input char_code, input font_bits);
    modport slave  (input char_addr, input font_addr, output char_code, output font_bits);
endinterface

// File: rtl/glyph_renderer.sv
// rtl/glyph_renderer.sv - 5-stage text-mode pixel pipeline (optional blinking cursor: GLYPH_CURSOR_EN)
module glyph_renderer #(
    parameter int COLS       = 25,
    parameter int ROWS       = 18,
    parameter int SCALE_LOG2 = 2,
    parameter int LATENCY    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
`ifdef GLYPH_CURSOR_EN
    input  logic [4:0]  cursor_col,
    input  logic [4:0]  cursor_row,
`endif
    glyph_renderer_if.master bus,
    input  logic [5:0]  fg_color,
    input  logic [5:0]  bg_color,
    output logic [5:0]  rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        display_on_out
);
    localparam int CELL_LOG2 = SCALE_LOG2 + 3;

    typedef struct packed {
        logic       de;
        logic       in_grid;
        logic [2:0] gx;
        logic [2:0] gy;
        logic       cur;
    } fetch_meta_t;

    // Once the font address is formed the glyph row index is no longer needed.
    typedef struct packed {
        logic       de;
        logic       in_grid;
        logic [2:0] gx;
        logic       cur;
    } pixel_meta_t;

    fetch_meta_t s1, s2;
    pixel_meta_t s3, s4;
    logic        inv3, inv4;
    logic [LATENCY-1:0] hs_sr, vs_sr, de_sr;

    logic [5:0] col;
    logic [4:0] row;
    logic [8:0] addr_d;
    logic       in_grid_d;
    logic       cur_d;
    logic       pix;

    assign col       = 6'(hpos >> CELL_LOG2);
    assign row       = 5'(vpos >> CELL_LOG2);
    assign addr_d    = 9'(row) * 9'(COLS) + 9'(col);
    assign in_grid_d = display_on && (col < 6'(COLS)) && (row < 5'(ROWS));

`ifdef GLYPH_CURSOR_EN
    logic [5:0] frame_cnt;
    logic       vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_in && !vsync_q)
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // in_grid_d already excludes any cursor position beyond the grid.
    assign cur_d = in_grid_d && !frame_cnt[5] &&
                   (col == 6'(cursor_col)) && (row == cursor_row);
`else
    assign cur_d = 1'b0;
`endif

    assign pix = bus.font_bits[3'd7 - s4.gx] ^ inv4 ^ s4.cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            s4            <= '0;
            inv3          <= 1'b0;
            inv4          <= 1'b0;
            bus.char_addr <= '0;
            bus.font_addr <= '0;
            rgb_out       <= '0;
            hs_sr         <= '0;
            vs_sr         <= '0;
            de_sr         <= '0;
        end else begin
            s1.de         <= display_on;
            s1.in_grid    <= in_grid_d;
            s1.gx         <= hpos[SCALE_LOG2 +: 3];
            s1.gy         <= vpos[SCALE_LOG2 +: 3];
            s1.cur        <= cur_d;
            bus.char_addr <= in_grid_d ? addr_d : 9'd0;

            s2 <= s1;

            // Character buffer output is valid here, one clock after char_addr.
            bus.font_addr <= {bus.char_code[6:0], s2.gy};
            inv3          <= bus.char_code[7];
            s3.de         <= s2.de;
            s3.in_grid    <= s2.in_grid;
            s3.gx         <= s2.gx;
            s3.cur        <= s2.cur;

            s4   <= s3;
            inv4 <= inv3;

            if (!s4.de)
                rgb_out <= '0;
            else if (!s4.in_grid)
                rgb_out <= bg_color;
            else
                rgb_out <= pix ? fg_color : bg_color;

            hs_sr <= {hs_sr[LATENCY-2:0], hsync_in};
            vs_sr <= {vs_sr[LATENCY-2:0], vsync_in};
            de_sr <= {de_sr[LATENCY-2:0], display_on};
        end
    end

    assign hsync_out      = hs_sr[LATENCY-1];
    assign vsync_out      = vs_sr[LATENCY-1];
    assign display_on_out = de_sr[LATENCY-1];
endmodule

// File: tb/tb_glyph_renderer.sv
// tb/tb_glyph_renderer.sv - randomized bench with a cell/pixel reference model for glyph_renderer
module tb_glyph_renderer;
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic        display_on, hsync_in, vsync_in;
    logic [5:0]  fg_color, bg_color, rgb_out;
    logic        hsync_out, vsync_out, display_on_out;
    logic [4:0]  cursor_col = 5'd0, cursor_row = 5'd0;

    glyph_renderer_if mem ();

    glyph_renderer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_on     (display_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
`ifdef GLYPH_CURSOR_EN
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
`endif
        .bus            (mem.master),
        .fg_color       (fg_color),
        .bg_color       (bg_color),
        .rgb_out        (rgb_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .display_on_out (display_on_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [10:0] hpos;
        logic [9:0]  vpos;
        logic        de, hs, vs;
        logic [5:0]  fg, bg;
        logic [4:0]  ccol, crow;
        logic [5:0]  fc;
    } rec_t;

    rec_t       hist [0:MAXC-1];
    int         cyc = 0;
    logic [7:0] char_mem [0:511];
    logic [7:0] font_mem [0:1023];
    int         ca_q = 0, fa_q = 0;
    int         mfc = 0;
    bit         mvs = 0;
    int         total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit cell_in_grid(rec_t r);
        return r.de && (r.hpos / 32) < 25 && (r.vpos / 32) < 18;
    endfunction

    function automatic int cell_addr(rec_t r);
        if (!cell_in_grid(r)) return 0;
        return (r.vpos / 32) * 25 + (r.hpos / 32);
    endfunction

    function automatic int exp_font_addr(rec_t r);
        return (char_mem[cell_addr(r)] % 128) * 8 + (r.vpos / 4) % 8;
    endfunction

    // Pixel for position a, with colours taken from the sample c one clock before the output edge.
    function automatic int exp_rgb(rec_t a, rec_t c);
        int ch, f, p;
        if (!a.de) return 0;
        if (!cell_in_grid(a)) return c.bg;
        ch = char_mem[cell_addr(a)];
        f  = font_mem[exp_font_addr(a)];
        p  = (f >> (7 - (a.hpos / 4) % 8)) & 1;
        p  = p ^ (ch >> 7);
`ifdef GLYPH_CURSOR_EN
        if (a.fc < 32 && (a.hpos / 32) == a.ccol && (a.vpos / 32) == a.crow) p = p ^ 1;
`endif
        return p ? c.fg : c.bg;
    endfunction

    function automatic bit reset_in(int lo, int hi);
        for (int k = lo; k <= hi; k++)
            if (k < 0 || !hist[k].rst_n) return 1'b1;
        return 1'b0;
    endfunction

    // Records the inputs applied for this clock, then plays the two 1-cycle-latency memories.
    task automatic tick();
        rec_t r;
        r.rst_n = rst_n; r.hpos = hpos; r.vpos = vpos;
        r.de = display_on; r.hs = hsync_in; r.vs = vsync_in;
        r.fg = fg_color; r.bg = bg_color;
        r.ccol = cursor_col; r.crow = cursor_row;
        r.fc = 6'(mfc);
        hist[cyc] = r;
        if (!rst_n) begin
            mfc = 0; mvs = 0;
        end else begin
            if (vsync_in && !mvs) mfc = (mfc + 1) % 64;
            mvs = vsync_in;
        end
        cyc++;
        @(negedge clk);
        #1;
        mem.char_code = char_mem[ca_q];
        ca_q          = int'(mem.char_addr);
        mem.font_bits = font_mem[fa_q];
        fa_q          = int'(mem.font_addr);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin : compare
        int j;
        j = cyc;
        if (j > 0) begin
            if (reset_in(j - 1, j - 1))
                chk("char_addr", 32'(mem.char_addr), 0);
            else
                chk("char_addr", 32'(mem.char_addr), cell_addr(hist[j - 1]));
            if (!reset_in(j - 3, j - 1))
                chk("font_addr", 32'(mem.font_addr), exp_font_addr(hist[j - 3]));
            if (reset_in(j - 5, j - 1)) begin
                chk("rgb_out", 32'(rgb_out), 0);
                chk("syncs", {29'd0, hsync_out, vsync_out, display_on_out}, 0);
            end else begin
                chk("rgb_out", 32'(rgb_out), exp_rgb(hist[j - 5], hist[j - 1]));
                chk("syncs", {29'd0, hsync_out, vsync_out, display_on_out},
                    {29'd0, hist[j - 5].hs, hist[j - 5].vs, hist[j - 5].de});
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++)  char_mem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) font_mem[i] = 8'($urandom);
        char_mem[53]    = 8'h41;
        font_mem[10'h209] = 8'h18;
        font_mem[10'h20A] = 8'h00;
        mem.char_code = 8'h00;
        mem.font_bits = 8'h00;

        rst_n = 0; display_on = 1; hsync_in = 1; vsync_in = 0;
        hpos = 11'd100; vpos = 10'd70; fg_color = 6'h3F; bg_color = 6'h00;
        ticks(2);
        chk("reset_rgb", 32'(rgb_out), 0);
        chk("reset_hsync", 32'(hsync_out), 0);
        chk("reset_de_out", 32'(display_on_out), 0);
        chk("reset_char_addr", 32'(mem.char_addr), 0);

        rst_n = 1;
        ticks(4);
        chk("hsync_before_5", 32'(hsync_out), 0);
        tick();
        chk("hsync_at_5", 32'(hsync_out), 1);
        hsync_in = 0;
        ticks(6);
        chk("decode_char_addr", 32'(mem.char_addr), 53);
        chk("decode_font_addr", 32'(mem.font_addr), 32'h209);
        chk("gx1_bg", 32'(rgb_out), 6'h00);

        hpos = 11'd108;
        ticks(4);
        chk("gx3_not_yet", 32'(rgb_out), 6'h00);
        tick();
        chk("gx3_fg", 32'(rgb_out), 6'h3F);
        hpos = 11'd100;
        ticks(5);
        chk("gx1_back_bg", 32'(rgb_out), 6'h00);

        display_on = 0;
        ticks(5);
        chk("blank_rgb", 32'(rgb_out), 0);
        chk("blank_de_out", 32'(display_on_out), 0);
        ticks(2);
        char_mem[53] = 8'hC1;
        display_on = 1; hpos = 11'd108;
        ticks(5);
        chk("inv_gx3", 32'(rgb_out), 6'h00);
        chk("inv_font_addr", 32'(mem.font_addr), 32'h209);
        hpos = 11'd100;
        ticks(5);
        chk("inv_gx1", 32'(rgb_out), 6'h3F);

        vpos = 10'd590; bg_color = 6'h15;
        ticks(5);
        chk("border_rgb", 32'(rgb_out), 6'h15);
        chk("border_char_addr", 32'(mem.char_addr), 0);

        display_on = 0;
        ticks(6);
        char_mem[53] = 8'h41;

`ifdef GLYPH_CURSOR_EN
        display_on = 1; hpos = 11'd100; vpos = 10'd72;
        cursor_col = 5'd3; cursor_row = 5'd2;
        ticks(6);
        chk("cursor_frame0", 32'(rgb_out), 6'h3F);
        for (int f = 0; f < 32; f++) begin
            vsync_in = 1; tick();
            vsync_in = 0; tick();
        end
        ticks(5);
        chk("cursor_frame32", 32'(rgb_out), 6'h15);
        for (int f = 0; f < 32; f++) begin
            vsync_in = 1; tick();
            vsync_in = 0; tick();
        end
        ticks(5);
        chk("cursor_frame64", 32'(rgb_out), 6'h3F);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            hpos       = 11'($urandom_range(0, 1055));
            vpos       = 10'($urandom_range(0, 627));
            display_on = ($urandom_range(0, 7) != 0);
            hsync_in   = 1'($urandom);
            vsync_in   = 1'($urandom);
            fg_color   = 6'($urandom);
            bg_color   = 6'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cursor_col = 5'($urandom_range(0, 31));
                cursor_row = 5'($urandom_range(0, 31));
            end
            tick();
        end
        rst_n = 1;
        ticks(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
